// File: rtl/kara_pkg.sv
// Shared constants and enums for the 60-bit Karatsuba GF(2)[x] multiplier.
// Used by the operand splitter, the dispatch front end and the recombiner.
package kara_pkg;

    localparam int N_OP      = 60;
    localparam int H_OP      = 30;
    localparam int SUBPROD_W = 59;
    localparam int RESULT_W  = 119;

    typedef enum logic [1:0] {
        TAG_LO  = 2'd0,
        TAG_MID = 2'd1,
        TAG_HI  = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_MID  = 2'd2,
        ST_HI   = 2'd3
    } state_e;

endpackage

// File: rtl/kara_split_60bit.sv
// Combinational Karatsuba splitter: lo/hi halves of each operand plus
// their GF(2) sum (lo ^ hi) used for the middle sub-product.
module kara_split_60bit
    import kara_pkg::*;
#(
    parameter  int N = N_OP,
    localparam int H = N / 2
) (
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [H-1:0] a_lo,
    output logic [H-1:0] a_hi,
    output logic [H-1:0] a_mid,
    output logic [H-1:0] b_lo,
    output logic [H-1:0] b_hi,
    output logic [H-1:0] b_mid
);

    assign a_lo  = a_in[H-1:0];
    assign a_hi  = a_in[N-1:H];
    assign b_lo  = b_in[H-1:0];
    assign b_hi  = b_in[N-1:H];
    assign a_mid = a_lo ^ a_hi;
    assign b_mid = b_lo ^ b_hi;

endmodule

// File: rtl/karatsuba_operand_dispatch_60bit.sv
// Karatsuba front end: captures one operand pair and issues the lo, mid
// and hi half-width pairs to the shared sub-multiplier, one per handshake.
module karatsuba_operand_dispatch_60bit
    import kara_pkg::*;
#(
    parameter  int N     = N_OP,
    parameter  int CNT_W = 16,
    localparam int H     = N / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic             sub_valid,
    input  logic             sub_ready,
    output logic [H-1:0]     sub_a,
    output logic [H-1:0]     sub_b,
    output logic [1:0]       sub_tag,
    output logic             sub_last,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic [H-1:0] a_lo, a_hi, a_mid;
    logic [H-1:0] b_lo, b_hi, b_mid;

    kara_split_60bit #(.N(N)) u_split (
        .a_in  (a_in),
        .b_in  (b_in),
        .a_lo  (a_lo),
        .a_hi  (a_hi),
        .a_mid (a_mid),
        .b_lo  (b_lo),
        .b_hi  (b_hi),
        .b_mid (b_mid)
    );

    state_e           state_q, state_d;
    logic [H-1:0]     a_mid_q, a_mid_d;
    logic [H-1:0]     b_mid_q, b_mid_d;
    logic [H-1:0]     a_hi_q, a_hi_d;
    logic [H-1:0]     b_hi_q, b_hi_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             sub_valid_q, sub_valid_d;
    logic [H-1:0]     sub_a_q, sub_a_d;
    logic [H-1:0]     sub_b_q, sub_b_d;
    logic [1:0]       sub_tag_q, sub_tag_d;
    logic             sub_last_q, sub_last_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             beat_done;

    assign beat_done = sub_valid_q && sub_ready;

    always_comb begin
        state_d     = state_q;
        a_mid_d     = a_mid_q;
        b_mid_d     = b_mid_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        sub_valid_d = sub_valid_q;
        sub_a_d     = sub_a_q;
        sub_b_d     = sub_b_q;
        sub_tag_d   = sub_tag_q;
        sub_last_d  = sub_last_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // lo pair goes straight to the output; mid/hi wait in regs
                    a_mid_d     = a_mid;
                    b_mid_d     = b_mid;
                    a_hi_d      = a_hi;
                    b_hi_d      = b_hi;
                    sub_a_d     = a_lo;
                    sub_b_d     = b_lo;
                    sub_tag_d   = TAG_LO;
                    sub_last_d  = 1'b0;
                    sub_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_LO;
                end
            end
            ST_LO: begin
                if (beat_done) begin
                    sub_a_d   = a_mid_q;
                    sub_b_d   = b_mid_q;
                    sub_tag_d = TAG_MID;
                    state_d   = ST_MID;
                end
            end
            ST_MID: begin
                if (beat_done) begin
                    sub_a_d    = a_hi_q;
                    sub_b_d    = b_hi_q;
                    sub_tag_d  = TAG_HI;
                    sub_last_d = 1'b1;
                    state_d    = ST_HI;
                end
            end
            ST_HI: begin
                if (beat_done) begin
                    sub_valid_d = 1'b0;
                    sub_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_mid_q     <= '0;
            b_mid_q     <= '0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            sub_valid_q <= 1'b0;
            sub_a_q     <= '0;
            sub_b_q     <= '0;
            sub_tag_q   <= TAG_LO;
            sub_last_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_mid_q     <= a_mid_d;
            b_mid_q     <= b_mid_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            sub_valid_q <= sub_valid_d;
            sub_a_q     <= sub_a_d;
            sub_b_q     <= sub_b_d;
            sub_tag_q   <= sub_tag_d;
            sub_last_q  <= sub_last_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign sub_valid = sub_valid_q;
    assign sub_a     = sub_a_q;
    assign sub_b     = sub_b_q;
    assign sub_tag   = sub_tag_q;
    assign sub_last  = sub_last_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_karatsuba_operand_dispatch_60bit.sv
// Directed bench for the Karatsuba operand dispatch front end.
module tb_karatsuba_operand_dispatch_60bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] a_in;
    logic [59:0] b_in;
    logic        sub_valid;
    logic        sub_ready;
    logic [29:0] sub_a;
    logic [29:0] sub_b;
    logic [1:0]  sub_tag;
    logic        sub_last;
    logic        busy;
    logic [15:0] op_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = '0;

    karatsuba_operand_dispatch_60bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_valid (sub_valid),
        .sub_ready (sub_ready),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_tag   (sub_tag),
        .sub_last  (sub_last),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [29:0] ea,
                               input logic [29:0] eb, input logic [1:0] et,
                               input logic el);
        check({tag, "_valid"}, 64'(sub_valid), 64'd1);
        check({tag, "_a"}, 64'(sub_a), 64'(ea));
        check({tag, "_b"}, 64'(sub_b), 64'(eb));
        check({tag, "_tag"}, 64'(sub_tag), 64'(et));
        check({tag, "_last"}, 64'(sub_last), 64'(el));
        check({tag, "_rdy"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 64'(sub_valid), 64'd0);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cnt"}, 64'(op_count), 64'(exp_count));
    endtask

    // Called at a negedge while idle; returns at the negedge after completion.
    task automatic do_op(input string nm, input logic [59:0] a,
                         input logic [59:0] b,
                         input logic [29:0] la, input logic [29:0] lb,
                         input logic [29:0] ma, input logic [29:0] mb,
                         input logic [29:0] ha, input logic [29:0] hb);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        sub_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_beat({nm, "_lo"}, la, lb, 2'd0, 1'b0);
        @(negedge clk);
        expect_beat({nm, "_mid"}, ma, mb, 2'd1, 1'b0);
        @(negedge clk);
        expect_beat({nm, "_hi"}, ha, hb, 2'd2, 1'b1);
        exp_count++;
        @(negedge clk);
        expect_idle({nm, "_done"});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sub_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_idle("rst0");
        check("rst0_a", 64'(sub_a), 64'd0);
        check("rst0_b", 64'(sub_b), 64'd0);
        check("rst0_tag", 64'(sub_tag), 64'd0);
        check("rst0_last", 64'(sub_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("basic", {30'h1, 30'h3}, {30'h2, 30'h5},
              30'h3, 30'h5, 30'h2, 30'h7, 30'h1, 30'h2);

        // Ready asserted while idle must not start anything
        sub_ready = 1'b1;
        @(negedge clk);
        expect_idle("idle_rdy");

        // Backpressure on the MID beat
        in_valid = 1'b1;
        a_in     = {30'h1, 30'h3};
        b_in     = {30'h2, 30'h5};
        @(negedge clk);
        in_valid = 1'b0;
        expect_beat("bp_lo", 30'h3, 30'h5, 2'd0, 1'b0);
        @(negedge clk);
        expect_beat("bp_mid", 30'h2, 30'h7, 2'd1, 1'b0);
        sub_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_beat("bp_hold", 30'h2, 30'h7, 2'd1, 1'b0);
        end
        sub_ready = 1'b1;
        @(negedge clk);
        expect_beat("bp_hi", 30'h1, 30'h2, 2'd2, 1'b1);
        exp_count++;
        @(negedge clk);
        expect_idle("bp_done");

        // New operands presented during LO..HI are held off until idle
        in_valid = 1'b1;
        a_in     = {30'h10, 30'h4};
        b_in     = {30'h8, 30'h1};
        @(negedge clk);
        a_in = {30'h3FFFFFFF, 30'h0};
        b_in = {30'h0, 30'h15};
        expect_beat("busy1_lo", 30'h4, 30'h1, 2'd0, 1'b0);
        @(negedge clk);
        expect_beat("busy1_mid", 30'h14, 30'h9, 2'd1, 1'b0);
        @(negedge clk);
        expect_beat("busy1_hi", 30'h10, 30'h8, 2'd2, 1'b1);
        exp_count++;
        @(negedge clk);
        expect_idle("busy_gap");
        @(negedge clk);
        in_valid = 1'b0;
        expect_beat("busy2_lo", 30'h0, 30'h15, 2'd0, 1'b0);
        @(negedge clk);
        expect_beat("busy2_mid", 30'h3FFFFFFF, 30'h15, 2'd1, 1'b0);
        @(negedge clk);
        expect_beat("busy2_hi", 30'h3FFFFFFF, 30'h0, 2'd2, 1'b1);
        exp_count++;
        @(negedge clk);
        expect_idle("busy2_done");

        do_op("ones", 60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF,
              30'h3FFFFFFF, 30'h3FFFFFFF, 30'h0, 30'h0,
              30'h3FFFFFFF, 30'h3FFFFFFF);
        do_op("zeros", 60'h0, 60'h0,
              30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0);

        // Asynchronous reset in the middle of an operation
        in_valid = 1'b1;
        a_in     = {30'h1, 30'h3};
        b_in     = {30'h2, 30'h5};
        @(negedge clk);
        in_valid = 1'b0;
        expect_beat("mid_rst_lo", 30'h3, 30'h5, 2'd0, 1'b0);
        #2 rst_n = 1'b0;
        exp_count = '0;
        #1;
        expect_idle("mid_rst");
        check("mid_rst_a", 64'(sub_a), 64'd0);
        check("mid_rst_tag", 64'(sub_tag), 64'd0);
        check("mid_rst_last", 64'(sub_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("post_rst");

        // Counter wrap
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        exp_count = 16'hFFFF;
        check("wrap_pre", 64'(op_count), 64'hFFFF);
        do_op("wrap", {30'h1, 30'h3}, {30'h2, 30'h5},
              30'h3, 30'h5, 30'h2, 30'h7, 30'h1, 30'h2);
        check("wrap_zero", 64'(op_count), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
